// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and instruction field positions.
// Jump predecode fields are used only with FETCH_PREDECODE_JMP_EN.
package cpu_fetch_pkg;

    localparam int ADDR_W   = 11;
    localparam int INSTR_W  = 29;

    localparam int OPC_MSB  = 28;
    localparam int OPC_LSB  = 24;
    localparam int COND_MSB = 19;
    localparam int COND_LSB = 16;

    localparam logic [4:0] OPC_JMP     = 5'h12;
    localparam logic [3:0] COND_ALWAYS = 4'h0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_jmp(
        input logic [INSTR_W-1:0] w
    );
        return (w[OPC_MSB:OPC_LSB] == OPC_JMP)
            && (w[COND_MSB:COND_LSB] == COND_ALWAYS);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO with flush; the head is held in registers so
// it keeps its last value while the queue is empty.
module fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic [PW:0]     cnt_nxt;

    always_comb begin
        cnt_nxt = count;
        if (push && !pop)
            cnt_nxt = count + ONE;
        else if (pop && !push)
            cnt_nxt = count - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else if (flush) begin
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count      <= cnt_nxt;
            head_valid <= (cnt_nxt != '0);
            // Head comes from the incoming word when it lands in an empty slot
            if (count == '0 || (pop && count == ONE)) begin
                if (push)
                    head <= wdata;
            end else if (pop) begin
                head <= mem[rptr + 1'b1];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: ROM addressing, redirect arbitration, prefetch queue.
// Optional jump folding enabled by FETCH_PREDECODE_JMP_EN.
module instr_fetch_unit #(
    parameter int ADDR_W = cpu_fetch_pkg::ADDR_W,
    parameter int INSTR_W = cpu_fetch_pkg::INSTR_W,
    parameter int DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  AddrROM,
    input  logic [INSTR_W-1:0] DataROM,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    input  logic               InstrReady,
    input  logic               RedirectValid,
    input  logic [ADDR_W-1:0]  RedirectPC
);

    import cpu_fetch_pkg::*;

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [CW:0]       count;
    logic              pop;
    logic              slot;
    logic              jmp;
    logic              push;
    fetch_entry_t      wdata;
    fetch_entry_t      head;

    assign pop  = InstrValid && InstrReady;
    assign slot = !RedirectValid && (count != FULL || pop);

`ifdef FETCH_PREDECODE_JMP_EN
    assign jmp = is_jmp(DataROM);
`else
    assign jmp = 1'b0;
`endif

    // A folded jump uses the fetch slot but never enters the queue
    assign push  = slot && !jmp;
    assign wdata = '{pc: fetch_pc, instr: DataROM};

    always_comb begin
        pc_nxt = fetch_pc;
        unique case (1'b1)
            RedirectValid: pc_nxt = RedirectPC;
            slot && jmp:   pc_nxt = DataROM[ADDR_W-1:0];
            slot:          pc_nxt = fetch_pc + 1'b1;
            default:       pc_nxt = fetch_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_pc <= RESET_PC;
        else
            fetch_pc <= pc_nxt;
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (RedirectValid),
        .push      (push),
        .pop       (pop),
        .wdata     (wdata),
        .count     (count),
        .head_valid(InstrValid),
        .head      (head)
    );

    assign AddrROM = fetch_pc;
    assign Instr   = head.instr;
    assign InstrPC = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model plus
// directed checks; honours FETCH_PREDECODE_JMP_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] AddrROM;
    logic [28:0] DataROM;
    logic        InstrValid;
    logic [28:0] Instr;
    logic [10:0] InstrPC;
    logic        InstrReady;
    logic        RedirectValid;
    logic [10:0] RedirectPC;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [28:0] rom(input logic [10:0] a);
        case (a)
            11'h000: return 29'h01f0c0ff;
            11'h001: return 29'h01000000;
            11'h06F: return 29'h010000ff;
            11'h07B: return 29'h1200006f;
            11'h07C: return 29'h0ab11000;
            11'h07D: return 29'h18000006;
            default: return {5'h03, 13'h0, a};
        endcase
    endfunction

    assign DataROM = rom(AddrROM);

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .AddrROM      (AddrROM),
        .DataROM      (DataROM),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady),
        .RedirectValid(RedirectValid),
        .RedirectPC   (RedirectPC)
    );

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    typedef struct {
        logic [10:0] pc;
        logic [28:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [10:0] mpc;
    logic [10:0] dpc;
    logic [28:0] dins;
    logic [28:0] w;
    bit          mpop;
    bit          mjmp;

    // Reference: fetch address, queue of {pc, word}, last shown head
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mpc  = 11'h000;
            dpc  = 11'h000;
            dins = 29'h0;
        end else begin
            mpop = (q.size() > 0) && InstrReady;
            w    = rom(mpc);
`ifdef FETCH_PREDECODE_JMP_EN
            mjmp = ((w >> 24) == 29'h12) && (((w >> 16) & 29'hF) == 0);
`else
            mjmp = 1'b0;
`endif
            if (RedirectValid) begin
                q.delete();
                mpc = RedirectPC;
            end else begin
                if (mpop)
                    void'(q.pop_front());
                if (q.size() < 2) begin
                    if (mjmp) begin
                        mpc = w[10:0];
                    end else begin
                        q.push_back('{pc: mpc, ins: w});
                        mpc = mpc + 11'd1;
                    end
                end
            end
            if (q.size() > 0) begin
                dpc  = q[0].pc;
                dins = q[0].ins;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 32'(InstrValid), 32'(q.size() > 0));
        chk("m_addr", 32'(AddrROM), 32'(mpc));
        chk("m_pc", 32'(InstrPC), 32'(dpc));
        chk("m_instr", 32'(Instr), 32'(dins));
    end

    logic [31:0] pat = 32'b1011_0011_1000_1101_0110_0001_1110_0101;

    initial begin
        rst_n         = 1'b0;
        InstrReady    = 1'b1;
        RedirectValid = 1'b0;
        RedirectPC    = 11'h000;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(InstrValid), 32'h0);
        chk("rst_addr", 32'(AddrROM), 32'h0);
        chk("rst_pc", 32'(InstrPC), 32'h0);
        chk("rst_instr", 32'(Instr), 32'h0);
        rst_n = 1'b1;

        @(negedge clk);
        chk("t1_valid", 32'(InstrValid), 32'h1);
        chk("t1_pc0", 32'(InstrPC), 32'h0);
        chk("t1_ins0", 32'(Instr), 32'h01f0c0ff);
        chk("t1_addr", 32'(AddrROM), 32'h1);
        @(negedge clk);
        chk("t1_pc1", 32'(InstrPC), 32'h1);
        chk("t1_ins1", 32'(Instr), 32'h01000000);
        repeat (3) @(negedge clk);

        InstrReady = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(InstrValid), 32'h0);
        chk("t5_addr", 32'(AddrROM), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) @(negedge clk);
        chk("t2_addr", 32'(AddrROM), 32'h2);
        chk("t2_head", 32'(InstrPC), 32'h0);
        chk("t2_valid", 32'(InstrValid), 32'h1);
        InstrReady = 1'b1;
        @(negedge clk);
        chk("t2_pc1", 32'(InstrPC), 32'h1);
        @(negedge clk);
        chk("t2_pc2", 32'(InstrPC), 32'h2);
        chk("t2_nogap", 32'(InstrValid), 32'h1);

        InstrReady = 1'b0;
        repeat (2) @(negedge clk);
        RedirectValid = 1'b1;
        RedirectPC    = 11'h07C;
        InstrReady    = 1'b1;
        @(negedge clk);
        chk("t3_bubble", 32'(InstrValid), 32'h0);
        RedirectValid = 1'b0;
        @(negedge clk);
        chk("t3_pc", 32'(InstrPC), 32'h07C);
        chk("t3_ins", 32'(Instr), 32'h0ab11000);
        @(negedge clk);
        chk("t3_pc2", 32'(InstrPC), 32'h07D);
        chk("t3_ins2", 32'(Instr), 32'h18000006);

        RedirectValid = 1'b1;
        RedirectPC    = 11'h100;
        @(negedge clk);
        RedirectPC = 11'h200;
        @(negedge clk);
        RedirectValid = 1'b0;
        @(negedge clk);
        chk("b2b_pc", 32'(InstrPC), 32'h200);

        RedirectValid = 1'b1;
        RedirectPC    = 11'h7FF;
        @(negedge clk);
        RedirectValid = 1'b0;
        @(negedge clk);
        chk("t4_pc", 32'(InstrPC), 32'h7FF);
        @(negedge clk);
        chk("t4_wrap", 32'(InstrPC), 32'h000);
        chk("t4_ins", 32'(Instr), 32'h01f0c0ff);

        RedirectValid = 1'b1;
        RedirectPC    = 11'h07B;
        @(negedge clk);
        RedirectValid = 1'b0;
`ifdef FETCH_PREDECODE_JMP_EN
        @(negedge clk);
        chk("t6_fold", 32'(InstrValid), 32'h0);
        @(negedge clk);
        chk("t6_pc", 32'(InstrPC), 32'h06F);
        chk("t6_ins", 32'(Instr), 32'h010000ff);
`else
        @(negedge clk);
        chk("t6_pc", 32'(InstrPC), 32'h07B);
        chk("t6_ins", 32'(Instr), 32'h1200006f);
`endif

        for (int i = 0; i < 32; i++) begin
            InstrReady    = pat[i];
            RedirectValid = (i == 20);
            RedirectPC    = 11'h7E0;
            @(negedge clk);
        end
        RedirectValid = 1'b0;
        InstrReady    = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
